tf_gen_param: RTL and testbench

//  Parametrised twiddle-factor generator for the NTT datapath; successor to the fixed 15-bank TF generator.

---
 rtl/tf_pkg.sv | 23 ++
 rtl/tf_gen_param_modmul.sv | 50 +++++
 rtl/tf_gen_param.sv | 174 +++++++++++++++++
 tb/tb_tf_gen_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tf_pkg
// Brief   : Shared constants and FSM encoding for the twiddle-factor generator.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package tf_pkg;

    localparam int unsigned c_TF_DW = 17;
    localparam int unsigned c_TF_Q  = 65537;

    // Barrett constant floor(2^(2*DW) / Q)
    localparam logic [2*c_TF_DW:0] c_TF_MU =
        ((2*c_TF_DW+1)'(1) << (2*c_TF_DW)) / (2*c_TF_DW+1)'(c_TF_Q);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_MUL   = 2'd2
    } tf_state_t;

endpackage
`default_nettype wire

// File: rtl/tf_gen_param_modmul.sv
`default_nettype none
// ============================================================================
// Module  : tf_modmul
// Brief   : a*b mod Q via Barrett reduction, followed by LAT pipeline stages.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module tf_modmul
    import tf_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic [c_TF_DW-1:0] i_a,
    input  logic [c_TF_DW-1:0] i_b,
    output logic [c_TF_DW-1:0] o_p
);

    localparam int DW = c_TF_DW;
    localparam int PW = 2 * DW;

    logic [PW-1:0] w_x;
    logic [2*PW:0] w_t;
    logic [PW-1:0] w_q;
    logic [PW-1:0] w_r0;
    logic [PW-1:0] w_r1;
    logic [PW-1:0] w_r2;
    logic [DW-1:0] w_res;

    assign w_x  = PW'(i_a) * PW'(i_b);
    assign w_t  = (2*PW+1)'(w_x) * (2*PW+1)'(c_TF_MU);
    assign w_q  = PW'(w_t >> PW);
    // Barrett quotient may undershoot by up to two, leaving a residue below 3Q
    assign w_r0 = w_x - w_q * PW'(c_TF_Q);
    assign w_r1 = (w_r0 >= PW'(c_TF_Q)) ? (w_r0 - PW'(c_TF_Q)) : w_r0;
    assign w_r2 = (w_r1 >= PW'(c_TF_Q)) ? (w_r1 - PW'(c_TF_Q)) : w_r1;
    assign w_res = DW'(w_r2);

    logic [DW-1:0] r_pipe [LAT];

    always_ff @(posedge clk) begin
        r_pipe[0] <= w_res;
        for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_p = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/tf_gen_param.sv
`default_nettype none
// ============================================================================
// Module  : tf_gen_param
// Brief   : Parametrised NTT twiddle generator: NBANK twiddles per step,
//           advanced in place by a per-stage constant mod Q.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module tf_gen_param
    import tf_pkg::*;
#(
    parameter int NBANK = 15,
    parameter int K     = 3,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cfg_we,
    input  logic                       i_cfg_is_const,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0] i_cfg_stage,
    input  logic [$clog2(NBANK + 1)-1:0]         i_cfg_bank,
    input  logic [c_TF_DW-1:0]         i_cfg_data,
    output logic                       o_cfg_err,
    input  logic                       i_start,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0] i_start_stage,
    output logic                       o_start_ready,
    input  logic                       i_step_valid,
    output logic                       o_step_ready,
    output logic                       o_tf_valid,
    output logic [NBANK*c_TF_DW-1:0]   o_tf_out
);

    localparam int DW  = c_TF_DW;
    localparam int SW  = (K > 1) ? $clog2(K) : 1;
    // Bank port is one code wider than needed so that NBANK itself is encodable and rejectable
    localparam int BW  = $clog2(NBANK + 1);
    localparam int BIW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    tf_state_t r_state;
    tf_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic w_load;
    logic w_accept;
    logic w_update;

    logic [DW-1:0] r_base  [K][NBANK];
    logic [DW-1:0] r_const [K];
    logic [DW-1:0] r_run   [NBANK];
    logic [DW-1:0] r_const_r;
    logic [DW-1:0] w_prod  [NBANK];
    logic [NBANK*DW-1:0] r_tf_out;
    logic r_tf_valid;
    logic r_cfg_err;

    logic          w_cfg_bad;
    logic [BIW-1:0] w_bank_idx;
    logic [SW-1:0] w_start_idx;

    assign w_cfg_bad = ({1'b0, i_cfg_stage} >= (SW+1)'(K))
                     | (~i_cfg_is_const & ({1'b0, i_cfg_bank} >= (BW+1)'(NBANK)))
                     | ({1'b0, i_cfg_data} >= (DW+1)'(c_TF_Q));
    assign w_bank_idx  = BIW'(i_cfg_bank);
    assign w_start_idx = ({1'b0, i_start_stage} < (SW+1)'(K)) ? i_start_stage : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_update    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (i_start) begin
                    w_load = 1'b1;
                end else if (i_step_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(LAT - 1)) begin
                    w_update    = 1'b1;
                    w_state_nxt = S_READY;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_start_ready = (r_state != S_MUL);
    assign o_step_ready  = (r_state == S_READY) & ~i_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < K; s++) begin
                r_const[s] <= '0;
                for (int b = 0; b < NBANK; b++) begin
                    r_base[s][b] <= '0;
                end
            end
            for (int b = 0; b < NBANK; b++) begin
                r_run[b] <= '0;
            end
            r_const_r  <= '0;
            r_tf_out   <= '0;
            r_tf_valid <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err  <= i_cfg_we & w_cfg_bad;
            r_tf_valid <= w_accept;
            if (i_cfg_we && !w_cfg_bad) begin
                if (i_cfg_is_const) begin
                    r_const[i_cfg_stage] <= i_cfg_data;
                end else begin
                    r_base[i_cfg_stage][w_bank_idx] <= i_cfg_data;
                end
            end
            if (w_accept) begin
                for (int b = 0; b < NBANK; b++) begin
                    r_tf_out[b*DW +: DW] <= r_run[b];
                end
            end
            if (w_load) begin
                r_const_r <= r_const[w_start_idx];
                for (int b = 0; b < NBANK; b++) begin
                    r_run[b] <= r_base[w_start_idx][b];
                end
            end else if (w_update) begin
                for (int b = 0; b < NBANK; b++) begin
                    r_run[b] <= w_prod[b];
                end
            end
        end
    end

    generate
        for (genvar b = 0; b < NBANK; b++) begin : g_bank
            tf_modmul #(
                .LAT (LAT)
            ) u_modmul (
                .clk (clk),
                .i_a (r_run[b]),
                .i_b (r_const_r),
                .o_p (w_prod[b])
            );
        end
    endgenerate

    assign o_tf_out   = r_tf_out;
    assign o_tf_valid = r_tf_valid;
    assign o_cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_tf_gen_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_tf_gen_param
// Brief   : Directed bench for tf_gen_param with NBANK=4, K=3, LAT=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tf_gen_param;

    localparam int NB  = 4;
    localparam int KS  = 3;
    localparam int LT  = 2;
    localparam int DW  = 17;
    localparam int OW  = NB * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_cfg_we = 1'b0;
    logic          i_cfg_is_const = 1'b0;
    logic [1:0]    i_cfg_stage = '0;
    logic [2:0]    i_cfg_bank = '0;
    logic [DW-1:0] i_cfg_data = '0;
    logic          o_cfg_err;
    logic          i_start = 1'b0;
    logic [1:0]    i_start_stage = '0;
    logic          o_start_ready;
    logic          i_step_valid = 1'b0;
    logic          o_step_ready;
    logic          o_tf_valid;
    logic [OW-1:0] o_tf_out;

    tf_gen_param #(
        .NBANK (NB),
        .K     (KS),
        .LAT   (LT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cfg_we       (i_cfg_we),
        .i_cfg_is_const (i_cfg_is_const),
        .i_cfg_stage    (i_cfg_stage),
        .i_cfg_bank     (i_cfg_bank),
        .i_cfg_data     (i_cfg_data),
        .o_cfg_err      (o_cfg_err),
        .i_start        (i_start),
        .i_start_stage  (i_start_stage),
        .o_start_ready  (o_start_ready),
        .i_step_valid   (i_step_valid),
        .o_step_ready   (o_step_ready),
        .o_tf_valid     (o_tf_valid),
        .o_tf_out       (o_tf_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          is_const;
        logic [1:0]    stage;
        logic [2:0]    bank;
        logic [DW-1:0] data;
        logic          exp_err;
    } cfg_vec_t;

    typedef struct {
        logic [DW-1:0]      cst;
        logic [OW-1:0]      base;
        logic [4:0][OW-1:0] exp;
    } seq_vec_t;

    cfg_vec_t cfg_tab [6];
    seq_vec_t seq_tab [3];

    function automatic logic [OW-1:0] pk(input int b3, input int b2, input int b1, input int b0);
        return {DW'(b3), DW'(b2), DW'(b1), DW'(b0)};
    endfunction

    function automatic logic [OW-1:0] rep(input int v);
        return pk(v, v, v, v);
    endfunction

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic is_const, input logic [1:0] stage,
                             input logic [2:0] bank, input logic [DW-1:0] data,
                             input logic exp_err, input string nm);
        i_cfg_we       = 1'b1;
        i_cfg_is_const = is_const;
        i_cfg_stage    = stage;
        i_cfg_bank     = bank;
        i_cfg_data     = data;
        tick();
        i_cfg_we = 1'b0;
        check(nm, OW'(o_cfg_err), OW'(exp_err));
    endtask

    task automatic do_start(input logic [1:0] stage, input string nm);
        int w = 0;
        i_start       = 1'b1;
        i_start_stage = stage;
        #1;
        while (!o_start_ready && w < 20) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (w >= 20) check({nm, "_start_timeout"}, OW'(1), OW'(0));
        tick();
        i_start = 1'b0;
        #1;
        check({nm, "_ready_after_start"}, OW'(o_step_ready), OW'(1));
    endtask

    task automatic do_step(input logic [OW-1:0] exp, input string nm);
        int w = 0;
        i_step_valid = 1'b1;
        #1;
        while (!o_step_ready && w < 20) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (w >= 20) check({nm, "_step_timeout"}, OW'(1), OW'(0));
        tick();
        i_step_valid = 1'b0;
        check({nm, "_tf_valid"}, OW'(o_tf_valid), OW'(1));
        check({nm, "_tf_out"}, o_tf_out, exp);
    endtask

    initial begin
        int acc_mask;
        int tfv_mask;
        int w;

        cfg_tab[0] = '{1'b0, 2'd3, 3'd0, 17'd5,      1'b1};
        cfg_tab[1] = '{1'b0, 2'd0, 3'd4, 17'd5,      1'b1};
        cfg_tab[2] = '{1'b0, 2'd0, 3'd0, 17'd65537,  1'b1};
        cfg_tab[3] = '{1'b1, 2'd3, 3'd0, 17'd5,      1'b1};
        cfg_tab[4] = '{1'b1, 2'd0, 3'd0, 17'd131071, 1'b1};
        cfg_tab[5] = '{1'b0, 2'd2, 3'd5, 17'd7,      1'b1};

        // stage 0: powers of 3
        seq_tab[0].cst  = 17'd3;
        seq_tab[0].base = rep(3);
        seq_tab[0].exp[0] = rep(3);
        seq_tab[0].exp[1] = rep(9);
        seq_tab[0].exp[2] = rep(27);
        seq_tab[0].exp[3] = rep(81);
        seq_tab[0].exp[4] = rep(243);
        // stage 1: multiply by Q-1, alternating sign
        seq_tab[1].cst  = 17'd65536;
        seq_tab[1].base = pk(3, 2, 1, 65536);
        seq_tab[1].exp[0] = pk(3, 2, 1, 65536);
        seq_tab[1].exp[1] = pk(65534, 65535, 65536, 1);
        seq_tab[1].exp[2] = pk(3, 2, 1, 65536);
        seq_tab[1].exp[3] = pk(65534, 65535, 65536, 1);
        seq_tab[1].exp[4] = pk(3, 2, 1, 65536);
        // stage 2: multiply by 256 (2^16 = -1 mod Q)
        seq_tab[2].cst  = 17'd256;
        seq_tab[2].base = pk(65536, 0, 2, 256);
        seq_tab[2].exp[0] = pk(65536, 0, 2, 256);
        seq_tab[2].exp[1] = pk(65281, 0, 512, 65536);
        seq_tab[2].exp[2] = pk(1, 0, 65535, 65281);
        seq_tab[2].exp[3] = pk(256, 0, 65025, 1);
        seq_tab[2].exp[4] = pk(65536, 0, 2, 256);

        #1;
        check("reset_tf_out",      o_tf_out,            '0);
        check("reset_tf_valid",    OW'(o_tf_valid),     OW'(0));
        check("reset_cfg_err",     OW'(o_cfg_err),      OW'(0));
        check("reset_step_ready",  OW'(o_step_ready),   OW'(0));
        check("reset_start_ready", OW'(o_start_ready),  OW'(1));
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int s = 0; s < KS; s++) begin
            cfg_write(1'b1, 2'(s), 3'd0, seq_tab[s].cst, 1'b0, $sformatf("load_const%0d", s));
            for (int b = 0; b < NB; b++) begin
                cfg_write(1'b0, 2'(s), 3'(b), seq_tab[s].base[b*DW +: DW], 1'b0,
                          $sformatf("load_base%0d_%0d", s, b));
            end
        end

        for (int i = 0; i < 6; i++) begin
            cfg_write(cfg_tab[i].is_const, cfg_tab[i].stage, cfg_tab[i].bank,
                      cfg_tab[i].data, cfg_tab[i].exp_err, $sformatf("cfg_err_vec%0d", i));
        end
        tick();
        check("cfg_err_clears", OW'(o_cfg_err), OW'(0));

        for (int s = 0; s < KS; s++) begin
            do_start(2'(s), $sformatf("seq%0d", s));
            for (int k = 0; k < 5; k++) begin
                do_step(seq_tab[s].exp[k], $sformatf("seq%0d_step%0d", s, k));
            end
        end

        do_start(2'd0, "thru");
        acc_mask = 0;
        tfv_mask = 0;
        for (int c = 0; c <= 10; c++) begin
            i_step_valid = (c < 10);
            #1;
            if (i_step_valid && o_step_ready) acc_mask |= (1 << c);
            if (o_tf_valid) tfv_mask |= (1 << c);
            tick();
        end
        i_step_valid = 1'b0;
        check("thru_accept_cycles",   OW'(acc_mask), OW'(585));
        check("thru_tf_valid_cycles", OW'(tfv_mask), OW'(1170));
        check("thru_last_tf_out",     o_tf_out,      rep(81));

        w = 0;
        #1;
        while (!o_step_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check("prio_wait_timeout", OW'(1), OW'(0));
        i_start       = 1'b1;
        i_start_stage = 2'd1;
        i_step_valid  = 1'b1;
        #1;
        check("prio_step_ready_low", OW'(o_step_ready), OW'(0));
        tick();
        i_start      = 1'b0;
        i_step_valid = 1'b0;
        check("prio_no_tf_valid", OW'(o_tf_valid), OW'(0));
        check("prio_tf_out_held", o_tf_out, rep(81));
        do_step(seq_tab[1].exp[0], "prio_reload");

        cfg_write(1'b1, 2'd1, 3'd0, 17'd3, 1'b0, "live_const_write");
        do_step(seq_tab[1].exp[1], "live_step1");
        do_step(seq_tab[1].exp[2], "live_step2");
        do_start(2'd1, "restart1");
        do_step(pk(3, 2, 1, 65536), "restart1_step0");
        do_step(pk(9, 6, 3, 65534), "restart1_step1");

        rst = 1'b1;
        #1;
        check("rst_mid_tf_out",      o_tf_out,           '0);
        check("rst_mid_tf_valid",    OW'(o_tf_valid),    OW'(0));
        check("rst_mid_cfg_err",     OW'(o_cfg_err),     OW'(0));
        check("rst_mid_start_ready", OW'(o_start_ready), OW'(1));
        tick();
        rst          = 1'b0;
        i_step_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("idle_step_ready_%0d", c), OW'(o_step_ready), OW'(0));
            check($sformatf("idle_tf_valid_%0d", c),   OW'(o_tf_valid),   OW'(0));
            tick();
        end
        i_step_valid = 1'b0;
        do_start(2'd0, "post_rst");
        do_step(rep(0), "post_rst_step");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
